complex_butterfly_pipe: RTL and testbench
=========================================

// Module: complex_butterfly_pipe
// PURPOSE
//  Pipelined radix-2 butterfly: A' = a+b, B' = a-b on complex operands (real/imag pairs).
//  Supplies the difference path that the plain complex sum lacks.
//  Sits between the twiddle multiplier and the stage memory of each FFT stage.
//  Valid/ready handshake on both sides; optional per-stage 1/2 scaling; saturation on overflow.
// PARAMETERS
//  DATA_WIDTH  16  signed two's-complement width of every real/imag component, in and out
//  SCALE       1   1: results arithmetic-shifted right by 1 (truncate toward -inf); 0: no shift, saturate
// PORTS
//  clk        in   1           rising-edge clock, sole clock domain
//  rst_n      in   1           synchronous reset, active-low
//  clr_ovf    in   1           synchronous clear of ovf_sticky
//  in_valid   in   1           operand pair valid
//  in_ready   out  1           block accepts operands this cycle
//  a_real     in   DATA_WIDTH  real part of operand a
//  a_imag     in   DATA_WIDTH  imaginary part of operand a
//  b_real     in   DATA_WIDTH  real part of operand b
//  b_imag     in   DATA_WIDTH  imaginary part of operand b
//  out_valid  out  1           results valid
//  out_ready  in   1           downstream accepts results
//  sum_real   out  DATA_WIDTH  real(a+b), scaled/saturated
//  sum_imag   out  DATA_WIDTH  imag(a+b), scaled/saturated
//  diff_real  out  DATA_WIDTH  real(a-b), scaled/saturated
//  diff_imag  out  DATA_WIDTH  imag(a-b), scaled/saturated
//  ovf_sticky out  1           set when any component saturated since last clear
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): both stage valids, out_valid, ovf_sticky <= 0; data outputs <= 0; in_ready=1 the cycle after.
//  - Two register stages. S1 registers the four sums/differences at DATA_WIDTH+1 bits, sign-extended.
//    S2 registers the scaled/saturated DATA_WIDTH results. Latency is 2 cycles from accept to out_valid with no stalls.
//  - Transfer rule: a handshake completes on any clk edge where valid && ready.
//    adv2 = s1_valid && (!out_valid || out_ready); in_ready = !s1_valid || adv2 (combinational, no bubble).
//  - Throughput is 1 per cycle while out_ready=1. Under stall, S2 holds its data and out_valid stays 1.
//    S1 holds one further item, then in_ready=0.
//  - out_valid drops only after a transfer with no new data from S1. Outputs are stable while out_valid && !out_ready.
//  - SCALE=1: out = wide >>> 1. This can never overflow, and ovf_sticky never sets.
//  - SCALE=0: if wide > 2^(W-1)-1, out = 2^(W-1)-1; if wide < -2^(W-1), out = -2^(W-1); ovf set in the same cycle S2 loads.
//  - ovf_sticky: set on any saturating S2 load. clr_ovf clears it, but a set in the same cycle wins.
//  - Data with valid=0 is ignored. Inputs are sampled only on accept.
//  - Reset mid-operation discards all in-flight items; nothing is emitted for them.
// TESTING
//  1. SCALE=1, a=(100,-50), b=(20,30), out_ready=1 -> 2 cycles later sum=(60,-10), diff=(40,-40), out_valid 1 cycle.
//  2. SCALE=0, a=(32767,0), b=(1,-32768), a_imag-b_imag=32768 -> sum_real=32767(sat), diff_imag=32767(sat), ovf_sticky=1;
//     clr_ovf -> 0.
//  3. SCALE=0, a=(-32768,-32768), b=(32767,1) -> diff_real=-32768(sat), sum_real=-1, ovf_sticky=1.
//  4. Stream 8 pairs back-to-back, out_ready=1 -> 8 results in order on consecutive cycles, in_ready stays 1.
//  5. Hold out_ready=0 after 1st result -> in_ready falls after 2 items accepted; outputs stable.
//     Release -> all items emerge in order, none lost or duplicated.
//  6. Assert rst_n=0 with 2 items in flight -> out_valid=0, ovf_sticky=0 next cycle; no stale results after release.

Source files
------------

// File: rtl/complex_butterfly_pipe.sv
// Two-stage pipelined radix-2 complex butterfly: sum = a+b, diff = a-b,
// with optional 1/2 scaling or saturation and a sticky overflow flag.
module complex_butterfly_pipe #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SCALE      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_ovf,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a_real,
    input  logic [DATA_WIDTH-1:0] a_imag,
    input  logic [DATA_WIDTH-1:0] b_real,
    input  logic [DATA_WIDTH-1:0] b_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum_real,
    output logic [DATA_WIDTH-1:0] sum_imag,
    output logic [DATA_WIDTH-1:0] diff_real,
    output logic [DATA_WIDTH-1:0] diff_imag,
    output logic                  ovf_sticky
);

    localparam int unsigned W = DATA_WIDTH;

    // Sign-extend one component to the S1 width.
    function automatic logic [W:0] ext(input logic [W-1:0] v);
        return {v[W-1], v};
    endfunction

    // Returns {saturated, value}; a wide value overflows W bits when its top two bits differ.
    function automatic logic [W:0] fmt(input logic [W:0] x);
        logic [W:0] r;
        if (SCALE != 0) begin
            r = {1'b0, x[W:1]};
        end else if (x[W] != x[W-1]) begin
            r = {1'b1, x[W], {(W-1){~x[W]}}};
        end else begin
            r = {1'b0, x[W-1:0]};
        end
        return r;
    endfunction

    logic         s1_valid;
    logic [W:0]   s1_sr, s1_si, s1_dr, s1_di;
    logic         adv2;
    logic         acc;
    logic [W:0]   f_sr, f_si, f_dr, f_di;
    logic         any_ovf;

    // Handshake and output formatting.
    always_comb begin
        adv2     = s1_valid && (!out_valid || out_ready);
        in_ready = !s1_valid || adv2;
        acc      = in_valid && in_ready;
        f_sr     = fmt(s1_sr);
        f_si     = fmt(s1_si);
        f_dr     = fmt(s1_dr);
        f_di     = fmt(s1_di);
        any_ovf  = f_sr[W] | f_si[W] | f_dr[W] | f_di[W];
    end

    // S1: full-precision sums and differences.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sr    <= '0;
            s1_si    <= '0;
            s1_dr    <= '0;
            s1_di    <= '0;
        end else begin
            if (acc) begin
                s1_valid <= 1'b1;
                s1_sr    <= ext(a_real) + ext(b_real);
                s1_si    <= ext(a_imag) + ext(b_imag);
                s1_dr    <= ext(a_real) - ext(b_real);
                s1_di    <= ext(a_imag) - ext(b_imag);
            end else if (adv2) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // S2: scaled/saturated results and sticky overflow (a set beats a clear).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            sum_real   <= '0;
            sum_imag   <= '0;
            diff_real  <= '0;
            diff_imag  <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (adv2) begin
                out_valid <= 1'b1;
                sum_real  <= f_sr[W-1:0];
                sum_imag  <= f_si[W-1:0];
                diff_real <= f_dr[W-1:0];
                diff_imag <= f_di[W-1:0];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (adv2 && any_ovf) begin
                ovf_sticky <= 1'b1;
            end else if (clr_ovf) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_complex_butterfly_pipe.sv
// Self-checking bench: a saturating (SCALE=0) and a halving (SCALE=1) instance
// share stimulus and are checked against an integer-arithmetic reference.
module tb_complex_butterfly_pipe;

    logic        clk = 1'b0;
    logic        rst_n, clr_ovf, in_valid, out_ready;
    logic [15:0] ar, ai, br, bi;
    logic        in_ready0, out_valid0, ovf0, in_ready1, out_valid1, ovf1;
    logic [15:0] sr0, si0, dr0, di0, sr1, si1, dr1, di1;
    logic [63:0] res0, res1;

    int checks = 0;
    int failures = 0;

    logic [63:0] acc_q[$];
    logic [63:0] got0_q[$];
    logic [63:0] got1_q[$];

    always #5 clk = ~clk;

    assign res0 = {sr0, si0, dr0, di0};
    assign res1 = {sr1, si1, dr1, di1};

    complex_butterfly_pipe #(.DATA_WIDTH(16), .SCALE(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr_ovf(clr_ovf), .in_valid(in_valid), .in_ready(in_ready0),
        .a_real(ar), .a_imag(ai), .b_real(br), .b_imag(bi),
        .out_valid(out_valid0), .out_ready(out_ready),
        .sum_real(sr0), .sum_imag(si0), .diff_real(dr0), .diff_imag(di0), .ovf_sticky(ovf0));

    complex_butterfly_pipe #(.DATA_WIDTH(16), .SCALE(1)) u_half (
        .clk(clk), .rst_n(rst_n), .clr_ovf(clr_ovf), .in_valid(in_valid), .in_ready(in_ready1),
        .a_real(ar), .a_imag(ai), .b_real(br), .b_imag(bi),
        .out_valid(out_valid1), .out_ready(out_ready),
        .sum_real(sr1), .sum_imag(si1), .diff_real(dr1), .diff_imag(di1), .ovf_sticky(ovf1));

    // Reference: exact integer result, then halve (floor) or clamp.
    function automatic logic [15:0] comp(input int wide, input int scale);
        int r;
        if (scale != 0) r = wide >>> 1;
        else if (wide > 32767) r = 32767;
        else if (wide < -32768) r = -32768;
        else r = wide;
        return 16'(r);
    endfunction

    function automatic logic [63:0] model(input logic [63:0] in, input int scale);
        int xr, xi, yr, yi;
        xr = $signed(in[63:48]);
        xi = $signed(in[47:32]);
        yr = $signed(in[31:16]);
        yi = $signed(in[15:0]);
        return {comp(xr + yr, scale), comp(xi + yi, scale), comp(xr - yr, scale), comp(xi - yi, scale)};
    endfunction

    function automatic bit saturates(input logic [63:0] in);
        int xr, xi, yr, yi;
        int w[4];
        bit s;
        xr = $signed(in[63:48]);
        xi = $signed(in[47:32]);
        yr = $signed(in[31:16]);
        yi = $signed(in[15:0]);
        w[0] = xr + yr; w[1] = xi + yi; w[2] = xr - yr; w[3] = xi - yi;
        s = 1'b0;
        for (int k = 0; k < 4; k++) if (w[k] > 32767 || w[k] < -32768) s = 1'b1;
        return s;
    endfunction

    // One clock: record handshakes just before the edge, return #1 after it.
    task automatic step();
        @(negedge clk);
        if (rst_n && in_valid && in_ready0) acc_q.push_back({ar, ai, br, bi});
        if (rst_n && out_ready && out_valid0) got0_q.push_back(res0);
        if (rst_n && out_ready && out_valid1) got1_q.push_back(res1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        acc_q.delete();
        got0_q.delete();
        got1_q.delete();
    endtask

    task automatic rand_in();
        ar = 16'($urandom); ai = 16'($urandom); br = 16'($urandom); bi = 16'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; clr_ovf = 1'b0;
        rand_in();
        repeat (3) step();
        checks++;
        if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got %b/%b want 0/0", out_valid0, out_valid1);
        end
        checks++;
        if (ovf0 !== 1'b0 || res0 !== 64'h0 || res1 !== 64'h0) begin
            failures++; $display("FAIL reset_data ovf=%b res0=%h res1=%h want 0", ovf0, res0, res1);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        checks++;
        if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1 || out_valid0 !== 1'b0) begin
            failures++; $display("FAIL reset_ready in_ready=%b/%b out_valid=%b want 1/1/0", in_ready0, in_ready1, out_valid0);
        end
    endtask

    task automatic test_basic();
        clear_q();
        ar = 16'd100; ai = 16'(-50); br = 16'd20; bi = 16'd30;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid1 !== 1'b0) begin
            failures++; $display("FAIL basic_early out_valid=%b want 0", out_valid1);
        end
        step();
        checks++;
        if (out_valid1 !== 1'b1 || res1 !== {16'd60, 16'(-10), 16'd40, 16'(-40)}) begin
            failures++; $display("FAIL basic_half valid=%b res=%h want 1 %h", out_valid1, res1, {16'd60, 16'(-10), 16'd40, 16'(-40)});
        end
        checks++;
        if (out_valid0 !== 1'b1 || res0 !== {16'd120, 16'(-20), 16'd80, 16'(-80)}) begin
            failures++; $display("FAIL basic_full valid=%b res=%h want 1 %h", out_valid0, res0, {16'd120, 16'(-20), 16'd80, 16'(-80)});
        end
        step();
        checks++;
        if (out_valid1 !== 1'b0 || ovf0 !== 1'b0) begin
            failures++; $display("FAIL basic_one_cycle out_valid=%b ovf=%b want 0/0", out_valid1, ovf0);
        end
    endtask

    task automatic test_saturation();
        ar = 16'h7FFF; ai = 16'h0000; br = 16'h0001; bi = 16'h8000;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (res0 !== 64'h7FFF_8000_7FFE_7FFF || ovf0 !== 1'b1 || ovf1 !== 1'b0) begin
            failures++; $display("FAIL sat_pos res=%h ovf=%b/%b want 7fff80007ffe7fff 1/0", res0, ovf0, ovf1);
        end
        step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++;
        if (ovf0 !== 1'b0) begin
            failures++; $display("FAIL sat_clear ovf=%b want 0", ovf0);
        end
        ar = 16'h8000; ai = 16'h8000; br = 16'h7FFF; bi = 16'h0001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (res0 !== 64'hFFFF_8001_8000_8000 || ovf0 !== 1'b1) begin
            failures++; $display("FAIL sat_neg res=%h ovf=%b want ffff800180008000 1", res0, ovf0);
        end
        checks++;
        if (res1 !== model({16'h8000, 16'h8000, 16'h7FFF, 16'h0001}, 1)) begin
            failures++; $display("FAIL half_neg res=%h want %h", res1, model({16'h8000, 16'h8000, 16'h7FFF, 16'h0001}, 1));
        end
        clr_ovf = 1'b1;
        step();
        checks++;
        if (ovf0 !== 1'b0) begin
            failures++; $display("FAIL sat_clear2 ovf=%b want 0", ovf0);
        end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (ovf0 !== 1'b1) begin
            failures++; $display("FAIL set_beats_clear ovf=%b want 1", ovf0);
        end
        step();
        clr_ovf = 1'b0;
        checks++;
        if (ovf0 !== 1'b0) begin
            failures++; $display("FAIL sat_clear3 ovf=%b want 0", ovf0);
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_in();
            in_valid = 1'b1;
            checks++;
            if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
                failures++; $display("FAIL b2b_ready beat=%0d in_ready=%b/%b want 1", i, in_ready0, in_ready1);
            end
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        checks++;
        if (acc_q.size() != 8 || got0_q.size() != 8 || got1_q.size() != 8) begin
            failures++; $display("FAIL b2b_count acc=%0d got=%0d/%0d want 8", acc_q.size(), got0_q.size(), got1_q.size());
        end
        for (int i = 0; i < acc_q.size() && i < got0_q.size() && i < got1_q.size(); i++) begin
            checks++;
            if (got0_q[i] !== model(acc_q[i], 0) || got1_q[i] !== model(acc_q[i], 1)) begin
                failures++; $display("FAIL b2b_data idx=%0d got=%h/%h want %h/%h", i, got0_q[i], got1_q[i], model(acc_q[i], 0), model(acc_q[i], 1));
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] hold0, hold1;
        clear_q();
        out_ready = 1'b1; in_valid = 1'b1;
        rand_in(); step();
        rand_in(); step();
        checks++;
        if (out_valid0 !== 1'b1) begin
            failures++; $display("FAIL stall_first out_valid=%b want 1", out_valid0);
        end
        out_ready = 1'b0;
        hold0 = res0; hold1 = res1;
        for (int k = 0; k < 5; k++) begin
            rand_in();
            step();
            checks++;
            if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1 || res0 !== hold0 || res1 !== hold1) begin
                failures++; $display("FAIL stall_hold cyc=%0d in_ready=%b out_valid=%b res=%h want 0 1 %h", k, in_ready0, out_valid0, res0, hold0);
            end
        end
        checks++;
        if (acc_q.size() != 2) begin
            failures++; $display("FAIL stall_accepted got=%0d want 2", acc_q.size());
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rand_in();
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (acc_q.size() != 6 || got0_q.size() != 6 || got1_q.size() != 6) begin
            failures++; $display("FAIL stall_count acc=%0d got=%0d/%0d want 6", acc_q.size(), got0_q.size(), got1_q.size());
        end
        for (int i = 0; i < acc_q.size() && i < got0_q.size() && i < got1_q.size(); i++) begin
            checks++;
            if (got0_q[i] !== model(acc_q[i], 0) || got1_q[i] !== model(acc_q[i], 1)) begin
                failures++; $display("FAIL stall_data idx=%0d got=%h/%h want %h/%h", i, got0_q[i], got1_q[i], model(acc_q[i], 0), model(acc_q[i], 1));
            end
        end
    endtask

    task automatic test_random();
        bit exp_ovf;
        clr_ovf = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        clr_ovf = 1'b0;
        clear_q();
        for (int c = 0; c < 300; c++) begin
            rand_in();
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        checks++;
        if (got0_q.size() != acc_q.size() || got1_q.size() != acc_q.size()) begin
            failures++; $display("FAIL rand_count acc=%0d got=%0d/%0d", acc_q.size(), got0_q.size(), got1_q.size());
        end
        exp_ovf = 1'b0;
        for (int i = 0; i < acc_q.size(); i++) exp_ovf |= saturates(acc_q[i]);
        for (int i = 0; i < acc_q.size() && i < got0_q.size() && i < got1_q.size(); i++) begin
            checks++;
            if (got0_q[i] !== model(acc_q[i], 0) || got1_q[i] !== model(acc_q[i], 1)) begin
                failures++; $display("FAIL rand_data idx=%0d got=%h/%h want %h/%h", i, got0_q[i], got1_q[i], model(acc_q[i], 0), model(acc_q[i], 1));
            end
        end
        checks++;
        if (ovf0 !== exp_ovf || ovf1 !== 1'b0) begin
            failures++; $display("FAIL rand_ovf got=%b/%b want %b/0", ovf0, ovf1, exp_ovf);
        end
    endtask

    task automatic test_reset_midflight();
        clear_q();
        ar = 16'h7FFF; ai = 16'h0000; br = 16'h0001; bi = 16'h8000;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        step();
        checks++;
        if (ovf0 !== 1'b1 || out_valid0 !== 1'b1) begin
            failures++; $display("FAIL mid_pre ovf=%b out_valid=%b want 1/1", ovf0, out_valid0);
        end
        rst_n = 1'b0; in_valid = 1'b0;
        step();
        checks++;
        if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || ovf0 !== 1'b0) begin
            failures++; $display("FAIL mid_reset out_valid=%b/%b ovf=%b want 0/0/0", out_valid0, out_valid1, ovf0);
        end
        clear_q();
        rst_n = 1'b1;
        repeat (4) step();
        checks++;
        if (got0_q.size() != 0 || got1_q.size() != 0 || out_valid0 !== 1'b0) begin
            failures++; $display("FAIL mid_stale got=%0d/%0d out_valid=%b want 0/0/0", got0_q.size(), got1_q.size(), out_valid0);
        end
    endtask

    initial begin
        rst_n = 1'b0; clr_ovf = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ar = '0; ai = '0; br = '0; bi = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
